// File: rtl/seq_gen_fx.sv
// Fixed-point generator for a0 = X, a(k+1) = a(k)^2 + X/a(k): multi-word operand load,
// back-pressurable term stream, and a coded error beat that terminates the stream.
module seq_gen_fx #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int IN_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              R_I,
  input  logic [IN_W-1:0]   dataIn,
  input  logic              o_ready,
  output logic              r_o,
  output logic [DATA_W-1:0] dataOut,
  output logic [1:0]        err,
  output logic              last,
  output logic              busy
);

  localparam int WORDS  = DATA_W / IN_W;
  localparam int NWORDS = 2 * WORDS;
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int KW     = DATA_W - FRAC_W;
  localparam int QW     = DATA_W + FRAC_W;
  localparam int DCW    = $clog2(QW + 1);
  localparam logic [QW-1:0] QLIM = QW'(1) << (DATA_W - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_CHECK, S_EMIT, S_OUT, S_CALC, S_SUM, S_ERR
  } state_t;

  state_t              state;
  logic [WCW-1:0]      wcnt;
  logic [2*DATA_W-1:0] ld_sr;
  logic [DATA_W-1:0]   a;
  logic [KW-1:0]       k;
  logic [1:0]          ecode;
  logic [DATA_W-1:0]   rem;
  logic [QW-1:0]       dq;
  logic [DATA_W-1:0]   dvs;
  logic [DCW-1:0]      dcnt;

  // Operands stay in the load shift register; it only moves while in LOAD.
  logic [DATA_W-1:0] x_op, n_op, x_mag, a_mag;
  logic [KW-1:0]     n_int;
  logic              n_bad;

  assign x_op  = ld_sr[2*DATA_W-1:DATA_W];
  assign n_op  = ld_sr[DATA_W-1:0];
  assign n_int = n_op[DATA_W-1:FRAC_W];
  assign n_bad = n_op[DATA_W-1] | (|n_op[FRAC_W-1:0]) | (n_int == '0);
  assign x_mag = x_op[DATA_W-1] ? (~x_op + DATA_W'(1)) : x_op;
  assign a_mag = a[DATA_W-1]    ? (~a + DATA_W'(1))    : a;

  // Restoring divider step: dq shifts the dividend out and the quotient in.
  logic [DATA_W:0] sh, trial;
  assign sh    = {rem, dq[QW-1]};
  assign trial = sh - {1'b0, dvs};

  logic signed [2*DATA_W-1:0] a_ext, sq, p_full;
  logic [DATA_W-1:0] q_val;
  logic [DATA_W:0]   s_ext;
  logic              q_neg, p_ovf, q_ovf, s_ovf;

  assign a_ext  = {{DATA_W{a[DATA_W-1]}}, a};
  assign sq     = a_ext * a_ext;
  assign p_full = sq >>> FRAC_W;
  assign p_ovf  = |p_full[2*DATA_W-1:DATA_W-1];
  assign q_neg  = x_op[DATA_W-1] ^ a[DATA_W-1];
  // A zero divisor would produce a saturated quotient; report it as overflow directly.
  assign q_ovf  = (dvs == '0) | (q_neg ? (dq > QLIM) : (dq >= QLIM));
  assign q_val  = q_neg ? (~dq[DATA_W-1:0] + DATA_W'(1)) : dq[DATA_W-1:0];
  assign s_ext  = {p_full[DATA_W-1], p_full[DATA_W-1:0]} + {q_val[DATA_W-1], q_val};
  assign s_ovf  = s_ext[DATA_W] ^ s_ext[DATA_W-1];

  assign busy = !(state == S_LOAD && wcnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_LOAD;
      wcnt    <= '0;
      ld_sr   <= '0;
      a       <= '0;
      k       <= '0;
      ecode   <= '0;
      rem     <= '0;
      dq      <= '0;
      dvs     <= '0;
      dcnt    <= '0;
      r_o     <= 1'b0;
      dataOut <= '0;
      err     <= '0;
      last    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (R_I) begin
            ld_sr <= {ld_sr[2*DATA_W-IN_W-1:0], dataIn};
            if (wcnt == WCW'(NWORDS - 1)) begin
              wcnt  <= '0;
              state <= S_CHECK;
            end else begin
              wcnt <= wcnt + WCW'(1);
            end
          end
        end
        S_CHECK: begin
          a     <= x_op;
          k     <= '0;
          ecode <= n_bad ? 2'b10 : ((x_op == '0) ? 2'b11 : 2'b00);
          state <= S_EMIT;
        end
        // Registers the beat so r_o never depends on o_ready.
        S_EMIT: begin
          r_o <= 1'b1;
          if (ecode != 2'b00) begin
            dataOut <= '0;
            err     <= ecode;
            last    <= 1'b1;
            state   <= S_ERR;
          end else begin
            dataOut <= a;
            err     <= 2'b00;
            last    <= (k == n_int - KW'(1));
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (o_ready) begin
            r_o  <= 1'b0;
            last <= 1'b0;
            if (last) begin
              state <= S_LOAD;
            end else begin
              rem   <= '0;
              dq    <= {x_mag, {FRAC_W{1'b0}}};
              dvs   <= a_mag;
              dcnt  <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= trial[DATA_W] ? sh[DATA_W-1:0] : trial[DATA_W-1:0];
          dq  <= {dq[QW-2:0], ~trial[DATA_W]};
          if (dcnt == DCW'(QW - 1)) state <= S_SUM;
          else                      dcnt  <= dcnt + DCW'(1);
        end
        S_SUM: begin
          if (p_ovf | q_ovf | s_ovf) begin
            ecode <= 2'b01;
          end else begin
            a <= s_ext[DATA_W-1:0];
            k <= k + KW'(1);
          end
          state <= S_EMIT;
        end
        S_ERR: begin
          if (o_ready) begin
            r_o   <= 1'b0;
            err   <= 2'b00;
            last  <= 1'b0;
            state <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
